// File: rtl/lcd_sprite_ctrl.sv
// Frame-synchronous sprite position controller: CPU shadow writes plus an autonomous bounce engine.
// Build macro LCD_SPRITE_WRAP_EN makes the auto-step wrap around the screen instead of bouncing.
module lcd_sprite_ctrl #(
    parameter int SCREEN_W    = 800,
    parameter int SCREEN_H    = 480,
    parameter int SPRITE_W    = 64,
    parameter int SPRITE_H    = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               frame_int_in,
    input  logic               cpu_wr_req,
    input  logic signed [15:0] cpu_wr_x,
    input  logic signed [15:0] cpu_wr_y,
    output logic               cpu_wr_ack,
    input  logic               mode_auto,
    input  logic        [3:0]  speed_x,
    input  logic        [3:0]  speed_y,
    output logic signed [15:0] offset_x,
    output logic signed [15:0] offset_y,
    output logic               busy,
    output logic        [15:0] frame_cnt,
    output logic               overrun
);
    localparam logic signed [15:0] XMAX = 16'(SCREEN_W - SPRITE_W);
    localparam logic signed [15:0] YMAX = 16'(SCREEN_H - SPRITE_H);

    typedef enum logic [1:0] {IDLE, COMMIT, STEP_X, STEP_Y} state_t;

    function automatic logic signed [15:0] clamp(input logic signed [15:0] v,
                                                 input logic signed [15:0] lim);
        if (v < 16'sd0)
            return 16'sd0;
        else if (v > lim)
            return lim;
        else
            return v;
    endfunction

    // Result is {dir_neg, position}; the sum is formed in 17 bits so it cannot overflow.
    function automatic logic [16:0] step_axis(input logic signed [15:0] pos,
                                              input logic               dir_neg,
                                              input logic        [3:0]  spd,
                                              input logic signed [15:0] lim);
        logic signed [16:0] posx;
        logic signed [16:0] limx;
        logic signed [16:0] spdx;
        logic signed [16:0] nx;
        posx = {pos[15], pos};
        limx = {lim[15], lim};
        spdx = {13'd0, spd};
        nx   = dir_neg ? (posx - spdx) : (posx + spdx);
`ifdef LCD_SPRITE_WRAP_EN
        if (nx > limx)
            nx = nx - (limx + 17'sd1);
        else if (nx < 17'sd0)
            nx = nx + (limx + 17'sd1);
        return {dir_neg, nx[15:0]};
`else
        if (nx >= limx)
            return {1'b1, lim};
        else if (nx <= 17'sd0)
            return {1'b0, 16'd0};
        else
            return {dir_neg, nx[15:0]};
`endif
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    state_t                 state_q;
    logic signed [15:0]     shadow_x_q;
    logic signed [15:0]     shadow_y_q;
    logic                   shadow_valid_q;
    logic                   dir_x_q;
    logic                   dir_y_q;
    logic signed [15:0]     off_x_q;
    logic signed [15:0]     off_y_q;
    logic                   ack_q;
    logic                   busy_q;
    logic [15:0]            cnt_q;
    logic                   ovr_q;

    logic                   frame_tick;
    logic                   accept;
    logic [15:0]            cnt_d;
    logic [16:0]            step_x_res;
    logic [16:0]            step_y_res;

    assign frame_tick = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
    assign accept     = (state_q == IDLE) && !frame_tick && cpu_wr_req;
    assign cnt_d      = cnt_q + 16'd1;
    assign step_x_res = step_axis(off_x_q, dir_x_q, speed_x, XMAX);
    assign step_y_res = step_axis(off_y_q, dir_y_q, speed_y, YMAX);

    // Shadow data is qualified by shadow_valid_q, so it carries no reset.
    always_ff @(posedge clk_sys) begin
        if (accept) begin
            shadow_x_q <= clamp(cpu_wr_x, XMAX);
            shadow_y_q <= clamp(cpu_wr_y, YMAX);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync_q         <= '0;
            sync_prev_q    <= 1'b0;
            state_q        <= IDLE;
            shadow_valid_q <= 1'b0;
            dir_x_q        <= 1'b0;
            dir_y_q        <= 1'b0;
            off_x_q        <= 16'sd0;
            off_y_q        <= 16'sd0;
            ack_q          <= 1'b0;
            busy_q         <= 1'b0;
            cnt_q          <= 16'd0;
            ovr_q          <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], frame_int_in};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
            ack_q       <= accept;
            if (accept)
                shadow_valid_q <= 1'b1;
            if (frame_tick && (state_q != IDLE))
                ovr_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (frame_tick) begin
                        state_q <= COMMIT;
                        busy_q  <= 1'b1;
                    end
                end
                COMMIT: begin
                    if (shadow_valid_q) begin
                        off_x_q        <= shadow_x_q;
                        off_y_q        <= shadow_y_q;
                        shadow_valid_q <= 1'b0;
                        dir_x_q        <= 1'b0;
                        dir_y_q        <= 1'b0;
                        cnt_q          <= cnt_d;
                        state_q        <= IDLE;
                        busy_q         <= 1'b0;
                    end else if (mode_auto) begin
                        state_q <= STEP_X;
                    end else begin
                        cnt_q   <= cnt_d;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                STEP_X: begin
                    off_x_q <= step_x_res[15:0];
                    dir_x_q <= step_x_res[16];
                    state_q <= STEP_Y;
                end
                STEP_Y: begin
                    off_y_q <= step_y_res[15:0];
                    dir_y_q <= step_y_res[16];
                    cnt_q   <= cnt_d;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_wr_ack = ack_q;
    assign offset_x   = off_x_q;
    assign offset_y   = off_y_q;
    assign busy       = busy_q;
    assign frame_cnt  = cnt_q;
    assign overrun    = ovr_q;
endmodule

// File: tb/tb_lcd_sprite_ctrl.sv
// Bench for lcd_sprite_ctrl: cycle-level reference model plus directed frames with hand-computed positions.
`timescale 1ns/1ps
module tb_lcd_sprite_ctrl;
    localparam int S    = 2;
    localparam int XMAX = 736;
    localparam int YMAX = 416;

    logic               clk_sys      = 1'b0;
    logic               reset        = 1'b1;
    logic               frame_int_in = 1'b0;
    logic               cpu_wr_req   = 1'b0;
    logic signed [15:0] cpu_wr_x     = 16'sd0;
    logic signed [15:0] cpu_wr_y     = 16'sd0;
    logic               mode_auto    = 1'b0;
    logic [3:0]         speed_x      = 4'd0;
    logic [3:0]         speed_y      = 4'd0;
    logic               cpu_wr_ack;
    logic signed [15:0] offset_x;
    logic signed [15:0] offset_y;
    logic               busy;
    logic [15:0]        frame_cnt;
    logic               overrun;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_sprite_ctrl #(
        .SCREEN_W(800), .SCREEN_H(480), .SPRITE_W(64), .SPRITE_H(64), .SYNC_STAGES(S)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .frame_int_in(frame_int_in),
        .cpu_wr_req(cpu_wr_req), .cpu_wr_x(cpu_wr_x), .cpu_wr_y(cpu_wr_y),
        .cpu_wr_ack(cpu_wr_ack), .mode_auto(mode_auto),
        .speed_x(speed_x), .speed_y(speed_y),
        .offset_x(offset_x), .offset_y(offset_y), .busy(busy),
        .frame_cnt(frame_cnt), .overrun(overrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: position arithmetic in plain ints, timing as "cycles since tick".
    int m_x, m_y, m_sx, m_sy, m_dx, m_dy, m_cnt, m_age;
    bit m_sv, m_ack, m_ovr;
    bit hist [0:S];

    function automatic int clampv(input int v, input int mx);
        return (v < 0) ? 0 : ((v > mx) ? mx : v);
    endfunction

    task automatic step_axis(input int pos, input int dir, input int spd, input int mx,
                             output int npos, output int ndir);
        int nx;
        nx   = pos + dir * spd;
        npos = nx;
        ndir = dir;
`ifdef LCD_SPRITE_WRAP_EN
        if (nx > mx)     npos = nx - (mx + 1);
        else if (nx < 0) npos = nx + (mx + 1);
`else
        if (nx >= mx) begin
            npos = mx;
            ndir = -1;
        end else if (nx <= 0) begin
            npos = 0;
            ndir = 1;
        end
`endif
    endtask

    task automatic model_step();
        bit tick;
        int np, nd;
        if (reset) begin
            m_x = 0; m_y = 0; m_sx = 0; m_sy = 0; m_dx = 1; m_dy = 1;
            m_cnt = 0; m_age = -1; m_sv = 0; m_ack = 0; m_ovr = 0;
            for (int k = 0; k <= S; k++) hist[k] = 1'b0;
            return;
        end
        tick  = hist[S-1] && !hist[S];
        m_ack = 1'b0;
        if (m_age == -1) begin
            if (tick) begin
                m_age = 1;
            end else if (cpu_wr_req) begin
                m_sx  = clampv(int'(cpu_wr_x), XMAX);
                m_sy  = clampv(int'(cpu_wr_y), YMAX);
                m_sv  = 1'b1;
                m_ack = 1'b1;
            end
        end else begin
            if (tick) m_ovr = 1'b1;
            if (m_age == 1) begin
                if (m_sv) begin
                    m_x = m_sx; m_y = m_sy; m_sv = 1'b0; m_dx = 1; m_dy = 1;
                    m_cnt = (m_cnt + 1) % 65536;
                    m_age = -1;
                end else if (mode_auto) begin
                    m_age = 2;
                end else begin
                    m_cnt = (m_cnt + 1) % 65536;
                    m_age = -1;
                end
            end else if (m_age == 2) begin
                step_axis(m_x, m_dx, int'(speed_x), XMAX, np, nd);
                m_x = np; m_dx = nd;
                m_age = 3;
            end else begin
                step_axis(m_y, m_dy, int'(speed_y), YMAX, np, nd);
                m_y = np; m_dy = nd;
                m_cnt = (m_cnt + 1) % 65536;
                m_age = -1;
            end
        end
        for (int k = S; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = frame_int_in;
    endtask

    initial begin
        forever begin
            @(posedge clk_sys);
            model_step();
            #1;
            check("offset_x",   int'(offset_x),   m_x);
            check("offset_y",   int'(offset_y),   m_y);
            check("cpu_wr_ack", int'(cpu_wr_ack), int'(m_ack));
            check("busy",       int'(busy),       (m_age != -1) ? 1 : 0);
            check("frame_cnt",  int'(frame_cnt),  m_cnt);
            check("overrun",    int'(overrun),    int'(m_ovr));
        end
    end

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk_sys);
            #1;
            n++;
        end while (!cpu_wr_ack && n < 50);
        check(name, int'(cpu_wr_ack), 1);
    endtask

    task automatic cpu_write(input int x, input int y);
        @(negedge clk_sys);
        cpu_wr_req = 1'b1;
        cpu_wr_x   = 16'(x);
        cpu_wr_y   = 16'(y);
        wait_ack("ack_seen");
        @(negedge clk_sys);
        cpu_wr_req = 1'b0;
    endtask

    task automatic frame_pulse();
        @(negedge clk_sys);
        frame_int_in = 1'b1;
        repeat (2) @(negedge clk_sys);
        frame_int_in = 1'b0;
        repeat (8) @(negedge clk_sys);
    endtask

    task automatic expect_pos(input string name, input int x, input int y, input int cnt);
        check({name, "_x"},   int'(offset_x),  x);
        check({name, "_y"},   int'(offset_y),  y);
        check({name, "_cnt"}, int'(frame_cnt), cnt);
    endtask

    initial begin
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        check("rst_off_x",   int'(offset_x),   0);
        check("rst_off_y",   int'(offset_y),   0);
        check("rst_cnt",     int'(frame_cnt),  0);
        check("rst_overrun", int'(overrun),    0);
        check("rst_ack",     int'(cpu_wr_ack), 0);

        // CPU write then one frame, with the commit latency pinned by hand.
        cpu_write(100, 200);
        @(negedge clk_sys);
        frame_int_in = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        frame_int_in = 1'b0;
        @(negedge clk_sys);
        check("lat_t1_x",    int'(offset_x), 0);
        check("lat_t1_busy", int'(busy),     1);
        @(negedge clk_sys);
        check("lat_t2_x",    int'(offset_x), 100);
        check("lat_t2_busy", int'(busy),     0);
        repeat (6) @(negedge clk_sys);
        expect_pos("wr1", 100, 200, 1);

        cpu_write(-5, 1000);
        frame_pulse();
        expect_pos("clamp", 0, 416, 2);

        // CPU write pending together with auto mode: the write wins, no step.
        mode_auto = 1'b1;
        speed_x   = 4'd15;
        speed_y   = 4'd15;
        cpu_write(50, 60);
        frame_pulse();
        expect_pos("cpu_wins", 50, 60, 3);

        cpu_write(730, 410);
        frame_pulse();
        expect_pos("start", 730, 410, 4);
        frame_pulse();
`ifdef LCD_SPRITE_WRAP_EN
        expect_pos("auto1", 8, 8, 5);
        frame_pulse();
        expect_pos("auto2", 23, 23, 6);
`else
        expect_pos("auto1", 736, 416, 5);
        frame_pulse();
        expect_pos("auto2", 721, 401, 6);
`endif

        // Second tick lands in STEP_X and is dropped.
        @(negedge clk_sys);
        frame_int_in = 1'b1;
        @(negedge clk_sys);
        frame_int_in = 1'b0;
        @(negedge clk_sys);
        frame_int_in = 1'b1;
        @(negedge clk_sys);
        frame_int_in = 1'b0;
        repeat (10) @(negedge clk_sys);
`ifdef LCD_SPRITE_WRAP_EN
        expect_pos("ovr", 38, 38, 7);
`else
        expect_pos("ovr", 706, 386, 7);
`endif
        check("ovr_flag", int'(overrun), 1);

        // Speed 0 on the limits, then speed 5 reveals the resulting directions.
        cpu_write(0, 416);
        frame_pulse();
        expect_pos("lim", 0, 416, 8);
        speed_x = 4'd0;
        speed_y = 4'd0;
        frame_pulse();
        expect_pos("spd0", 0, 416, 9);
        speed_x = 4'd5;
        speed_y = 4'd5;
        frame_pulse();
`ifdef LCD_SPRITE_WRAP_EN
        expect_pos("spd5", 5, 4, 10);
`else
        expect_pos("spd5", 5, 411, 10);
`endif

        // Held request is accepted twice; the later data is committed.
        mode_auto = 1'b0;
        @(negedge clk_sys);
        cpu_wr_req = 1'b1;
        cpu_wr_x   = 16'sd10;
        cpu_wr_y   = 16'sd20;
        wait_ack("hold_ack1");
        @(negedge clk_sys);
        cpu_wr_x = 16'sd30;
        cpu_wr_y = 16'sd40;
        wait_ack("hold_ack2");
        @(negedge clk_sys);
        cpu_wr_req = 1'b0;
        frame_pulse();
        expect_pos("hold", 30, 40, 11);

`ifdef LCD_SPRITE_WRAP_EN
        cpu_write(730, 0);
        frame_pulse();
        expect_pos("wrap_start", 730, 0, 12);
        mode_auto = 1'b1;
        speed_x   = 4'd10;
        speed_y   = 4'd0;
        frame_pulse();
        expect_pos("wrap", 3, 0, 13);
        mode_auto = 1'b0;
`endif

        // Reset with a write pending in the shadow: the write is lost.
        cpu_write(123, 45);
        @(negedge clk_sys);
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        expect_pos("rst_mid", 0, 0, 0);
        check("rst_mid_ovr", int'(overrun), 0);
        frame_pulse();
        expect_pos("rst_lost", 0, 0, 1);

        repeat (3) @(negedge clk_sys);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
